dec_onehot_seq: RTL and testbench

Parametrised registered binary-to-one-hot decoder with valid/ready handshake and an optional self-timed scan mode. Decodes a SEL_W-bit select into a 2^SEL_W one-hot word held in an output register. Its scan mode walks the active output across all lines with a programmable dwell. Used as the select/enable generator for banked peripherals and multiplexed display/strobe lines downstream of control logic.

---
 rtl/dec_pkg.sv | 13 +
 rtl/dec_scan_ctr.sv | 39 +++
 rtl/dec_onehot_seq.sv | 134 +++++++++++++
 tb/tb_dec_onehot_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types for the one-hot decoder/sequencer: FSM states and mode encodings.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/dec_scan_ctr.sv
// Dwell counter plus wrapping line index for the scan mode of dec_onehot_seq.
// Only compiled when DEC_SCAN_EN is defined.
`ifdef DEC_SCAN_EN
module dec_scan_ctr #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step,
  output logic [SEL_W-1:0]   index,
  output logic               wrap
);

  logic [DWELL_W-1:0] cnt;

  // dwell is compared live, so a new value affects the line already showing
  assign step = run && (cnt == dwell);
  assign wrap = step && (&index);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      index <= '0;
    end else if (!run) begin
      cnt   <= '0;
      index <= '0;
    end else if (step) begin
      cnt   <= '0;
      index <= index + SEL_W'(1);
    end else begin
      cnt   <= cnt + DWELL_W'(1);
    end
  end

endmodule
`endif

// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot decoder with valid/ready handshake.
// Self-timed scan mode is built only when DEC_SCAN_EN is defined.
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**SEL_W-1:0] dec_out,
  output logic                scan_wrap
);

  localparam int OUT_W = 2**SEL_W;

  state_t           state, next_state;
  logic             mode_eff;
  logic             accept;
  logic [OUT_W-1:0] dec_nxt;
  logic             vld_nxt;
  logic             wrap_nxt;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

`ifdef DEC_SCAN_EN
  logic             scan_run;
  logic             scan_step;
  logic             scan_wrap_evt;
  logic [SEL_W-1:0] scan_index;
  logic [SEL_W-1:0] scan_index_nxt;

  assign mode_eff       = mode;
  assign scan_run       = (state == SCAN) && (next_state == SCAN);
  assign scan_index_nxt = scan_index + SEL_W'(1);

  dec_scan_ctr #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (scan_run),
    .dwell (dwell),
    .step  (scan_step),
    .index (scan_index),
    .wrap  (scan_wrap_evt)
  );
`else
  logic unused_ok;

  assign mode_eff  = MODE_DEC;
  assign unused_ok = &{1'b0, mode, dwell};
`endif

  assign in_ready = (state == DEC) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    next_state = state;
    dec_nxt    = dec_out;
    vld_nxt    = out_valid;
    wrap_nxt   = 1'b0;

    unique case (state)
      IDLE:    if (en) next_state = (mode_eff == MODE_SCAN) ? SCAN : DEC;
      DEC:     if (!en || mode_eff == MODE_SCAN) next_state = IDLE;
      SCAN:    if (!en || mode_eff == MODE_DEC) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Leaving any active state drops the held word, including a pending DEC word
    if (next_state == IDLE || state == IDLE) begin
      dec_nxt = '0;
      vld_nxt = 1'b0;
`ifdef DEC_SCAN_EN
      if (next_state == SCAN) begin
        dec_nxt = onehot('0);
        vld_nxt = 1'b1;
      end
`endif
    end else if (state == DEC) begin
      if (accept) begin
        dec_nxt = onehot(sel);
        vld_nxt = 1'b1;
      end else if (out_valid && out_ready) begin
        dec_nxt = '0;
        vld_nxt = 1'b0;
      end
    end
`ifdef DEC_SCAN_EN
    else if (scan_step) begin
      dec_nxt  = onehot(scan_index_nxt);
      wrap_nxt = scan_wrap_evt;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dec_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      dec_out   <= dec_nxt;
      out_valid <= vld_nxt;
    end
  end

`ifdef DEC_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_wrap <= 1'b0;
    else        scan_wrap <= wrap_nxt;
  end
`else
  logic unused_wrap;

  assign unused_wrap = wrap_nxt;
  assign scan_wrap   = 1'b0;
`endif

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq (SEL_W=2); scan checks follow DEC_SCAN_EN.
module tb_dec_onehot_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [7:0] dwell;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dec_out;
  logic       scan_wrap;

  typedef struct packed {
    logic [3:0] line;
    logic       wrap;
  } scan_exp_t;

  logic [3:0] line_tab [4];
  logic [3:0] sb [$];
  scan_exp_t  sq [$];
  int         total;
  int         bad;

  dec_onehot_seq #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .dwell     (dwell),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dec_out   (dec_out),
    .scan_wrap (scan_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive-side: a word accepted now is expected on dec_out right after the edge
  task automatic tick();
    bit         acc;
    logic [3:0] e;
    #1;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(line_tab[sel]);
    @(posedge clk);
    #1;
    if (acc) begin
      e = sb.pop_front();
      chk("dec_word", dec_out, e);
      chk("dec_vld", out_valid, 1);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    line_tab[0] = 4'b0001;
    line_tab[1] = 4'b0010;
    line_tab[2] = 4'b0100;
    line_tab[3] = 4'b1000;
    rst_n       = 1'b0;
    en          = 1'b0;
    mode        = 1'b0;
    in_valid    = 1'b0;
    sel         = '0;
    dwell       = 8'd2;
    out_ready   = 1'b0;

    #12;
    chk("rst_dec", dec_out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_wrap", scan_wrap, 0);
    #10;
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;
    chk("dec_entry_vld", out_valid, 0);
    chk("dec_entry_rdy", in_ready, 1);

    // Back-to-back stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
    end

    // Backpressure
    sel = 2'd2;
    tick();
    out_ready = 1'b0;
    sel       = 2'd3;
    #1;
    chk("bp_rdy", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", dec_out, 4'b0100);
      chk("bp_hold_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    sel       = 2'd1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pop_vld", out_valid, 0);
    chk("pop_dec", dec_out, 0);

    // Pending word dropped on disable
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sel       = 2'd3;
    tick();
    in_valid = 1'b0;
    en       = 1'b0;
    tick();
    chk("drop_vld", out_valid, 0);
    chk("drop_dec", dec_out, 0);
    chk("drop_rdy", in_ready, 0);

`ifdef DEC_SCAN_EN
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 3; r++) sq.push_back('{line: line_tab[l], wrap: 1'b0});
    sq.push_back('{line: 4'b0001, wrap: 1'b1});
    sq.push_back('{line: 4'b0010, wrap: 1'b0});
    sq.push_back('{line: 4'b0100, wrap: 1'b0});
    sq.push_back('{line: 4'b1000, wrap: 1'b0});
    sq.push_back('{line: 4'b0001, wrap: 1'b1});

    en       = 1'b1;
    mode     = 1'b1;
    dwell    = 8'd2;
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      scan_exp_t e;
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      e = sq.pop_front();
      chk("scan_line", dec_out, e.line);
      chk("scan_wrap", scan_wrap, e.wrap);
      chk("scan_vld", out_valid, 1);
      chk("scan_rdy", in_ready, 0);
      out_ready = k[0];
      if (k == 12) dwell = 8'd0;
    end

    // Mode change passes through IDLE
    mode     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mchg_dec", dec_out, 0);
    chk("mchg_vld", out_valid, 0);
    chk("mchg_rdy", in_ready, 0);
    chk("mchg_wrap", scan_wrap, 0);
    @(posedge clk);
    #1;
    chk("mchg_dec_rdy", in_ready, 1);

    // Async reset mid-scan
    mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scan_pre_rst", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
`else
    // Scan mode absent: mode=1 still decodes
    en       = 1'b1;
    mode     = 1'b1;
    @(posedge clk);
    #1;
    chk("ns_rdy", in_ready, 1);
    chk("ns_wrap", scan_wrap, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 2'd1;
    tick();
    chk("ns_wrap2", scan_wrap, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
`endif
    chk("arst_dec", dec_out, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_wrap", scan_wrap, 0);
    chk("sb_empty", sb.size(), 0);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
